gouram_trace_serialiser: RTL and testbench

- Downstream consumer of the Gouram trace unit.
- Accepts one packed trace_format record per cycle from the WB tracker output and buffers records in a FIFO.
- Serialises each record into 32-bit words on a valid/ready stream for an off-chip or AXI-Stream trace sink.
- Counts records dropped on overflow so software can detect gaps.

---
 rtl/gouram_datatypes_pkg.sv | 20 ++
 rtl/gouram_trace_fifo.sv | 56 +++++
 rtl/gouram_trace_serialiser.sv | 181 ++++++++++++++++++
 tb/tb_gouram_trace_serialiser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_datatypes_pkg.sv
// Shared types and constants for the Gouram trace path: the serialiser FSM state
// encoding, the optional header magic, and the fixed stream word width.
package gouram_datatypes;

    localparam logic [7:0] TRACE_HDR_MAGIC = 8'hA5;
    localparam int         OUT_WIDTH       = 32;
    localparam int         TRACE_SEQ_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } ser_state_t;

    // Number of stream words needed to carry a record of the given width.
    function automatic int trace_words(input int trace_width);
        return (trace_width + OUT_WIDTH - 1) / OUT_WIDTH;
    endfunction

endpackage

// File: rtl/gouram_trace_fifo.sv
// Parameterised synchronous FIFO with an extra pointer MSB for full/empty
// detection. A push on a full FIFO is refused even if a pop happens in the same cycle.
module gouram_trace_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        push_en  = push_i && !full_o;
        pop_en   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_en};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/gouram_trace_serialiser.sv
// Buffers Gouram trace records and serialises them LSW-first onto a 32-bit valid/ready stream.
// Define GOURAM_TRACE_HEADER_EN to prefix each record with a {magic, words, sequence} header word.
module gouram_trace_serialiser #(
    parameter int TRACE_WIDTH    = 128,
    parameter int FIFO_DEPTH     = 16,
    parameter int OUT_WIDTH      = 32,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trace_valid_i,
    input  logic [TRACE_WIDTH-1:0]        trace_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [OUT_WIDTH-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count_o,
    input  logic                          clr_overflow_i
);

    import gouram_datatypes::*;

    localparam int WORDS  = (TRACE_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int DATA_W = WORDS * OUT_WIDTH;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
`ifdef GOURAM_TRACE_HEADER_EN
    localparam int ENTRY_W = TRACE_WIDTH + TRACE_SEQ_WIDTH;
    localparam int SHIFT_W = DATA_W + OUT_WIDTH;
`else
    localparam int ENTRY_W = TRACE_WIDTH;
    localparam int SHIFT_W = DATA_W;
`endif

    ser_state_t                 state_q, state_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic                       overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ENTRY_W-1:0]         fifo_wdata;
    logic [ENTRY_W-1:0]         fifo_rdata;
    logic [SHIFT_W-1:0]         load_value;
    logic                       load;
    logic                       hs;
    logic                       drop;

`ifdef GOURAM_TRACE_HEADER_EN
    logic [TRACE_SEQ_WIDTH-1:0] seq_q, seq_d;

    // Sequence is stamped at arrival so dropped records leave a visible gap.
    assign seq_d      = trace_valid_i ? seq_q + TRACE_SEQ_WIDTH'(1) : seq_q;
    assign fifo_wdata = {seq_q, trace_data_i};
    assign load_value = {DATA_W'(fifo_rdata[TRACE_WIDTH-1:0]), TRACE_HDR_MAGIC, 8'(WORDS),
                         fifo_rdata[ENTRY_W-1:TRACE_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seq_q <= '0;
        else      seq_q <= seq_d;
    end
`else
    assign fifo_wdata = trace_data_i;
    assign load_value = DATA_W'(fifo_rdata);
`endif

    gouram_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (trace_valid_i),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign hs   = out_valid_q && out_ready_i;
    assign drop = trace_valid_i && fifo_full;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        load        = 1'b0;

        case (state_q)
            IDLE: load = !fifo_empty;
`ifdef GOURAM_TRACE_HEADER_EN
            HDR: if (hs) begin
                shift_d    = shift_q >> OUT_WIDTH;
                idx_d      = '0;
                out_last_d = (LAST_IDX == '0);
                state_d    = SEND;
            end
`endif
            SEND: if (hs) begin
                if (idx_q == LAST_IDX) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        shift_d     = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end else begin
                    shift_d    = shift_q >> OUT_WIDTH;
                    idx_d      = idx_q + IDX_W'(1);
                    out_last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d     = load_value;
            idx_d       = '0;
            out_valid_d = 1'b1;
`ifdef GOURAM_TRACE_HEADER_EN
            out_last_d  = 1'b0;
            state_d     = HDR;
`else
            out_last_d  = (LAST_IDX == '0);
            state_d     = SEND;
`endif
        end
        fifo_pop = load;
    end

    // A clear in the same cycle as a drop wins.
    always_comb begin
        overflow_d = clr_overflow_i ? 1'b0 : (overflow_q || drop);
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow_i) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign out_data_o   = shift_q[OUT_WIDTH-1:0];
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_gouram_trace_serialiser.sv
// Directed bench for gouram_trace_serialiser: vector table for single records plus hand-written
// sequences for backpressure, back-to-back, overflow, and async reset. Honours GOURAM_TRACE_HEADER_EN.
module tb_gouram_trace_serialiser;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         trace_valid_i = 1'b0;
    logic [127:0] trace_data_i = '0;
    logic         out_ready_i = 1'b0;
    logic         clr_overflow_i = 1'b0;
    logic         out_valid_o;
    logic [31:0]  out_data_o;
    logic         out_last_o;
    logic [4:0]   fifo_level_o;
    logic         overflow_o;
    logic [15:0]  drop_count_o;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [15:0]  seq_exp = '0;

    typedef struct {
        logic [127:0]      rec;
        logic [3:0][31:0]  w;   // w[k] = expected stream word k
    } vec_t;

    vec_t vecs [4];

    gouram_trace_serialiser dut (
        .clk            (clk),
        .rst            (rst),
        .trace_valid_i  (trace_valid_i),
        .trace_data_i   (trace_data_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_last_o     (out_last_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .drop_count_o   (drop_count_o),
        .clr_overflow_i (clr_overflow_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] rec);
        trace_valid_i = 1'b1;
        trace_data_i  = rec;
        step();
        trace_valid_i = 1'b0;
        seq_exp++;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid_o && n < 10) begin
            step();
            n++;
        end
        check({tag, "_valid_timeout"}, out_valid_o, 1'b1);
    endtask

    // Consumes the header word when headers are enabled; expects out_ready_i=1.
    task automatic check_hdr(input logic [15:0] seq);
`ifdef GOURAM_TRACE_HEADER_EN
        check("hdr_valid", out_valid_o, 1'b1);
        check("hdr_word", out_data_o, {8'hA5, 8'h04, seq});
        check("hdr_last", out_last_o, 1'b0);
        step();
`endif
    endtask

    task automatic check_words(input vec_t v, input int from_k);
        for (int k = from_k; k < 4; k++) begin
            check($sformatf("word%0d_valid", k), out_valid_o, 1'b1);
            check($sformatf("word%0d_data", k), out_data_o, v.w[k]);
            check($sformatf("word%0d_last", k), out_last_o, (k == 3));
            step();
        end
    endtask

    initial begin
        logic [15:0] s;
        int          n;

        vecs[0].rec = 128'h0003_0002_0001_0000;
        vecs[0].w   = {32'h0000_0000, 32'h0000_0000, 32'h0003_0002, 32'h0001_0000};
        vecs[1].rec = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        vecs[1].w   = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        vecs[2].rec = {128{1'b1}};
        vecs[2].w   = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3].rec = 128'h80000000_00000000_00000000_00000001;
        vecs[3].w   = {32'h80000000, 32'h00000000, 32'h00000000, 32'h00000001};

        // Reset state
        #1;
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_last", out_last_o, 1'b0);
        check("rst_data", out_data_o, 32'h0);
        check("rst_level", fifo_level_o, 5'd0);
        check("rst_overflow", overflow_o, 1'b0);
        check("rst_drop", drop_count_o, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        out_ready_i = 1'b1;

        // Single records: two-cycle latency, LSW first, last on word 4 only
        for (int i = 0; i < 4; i++) begin
            s = seq_exp;
            push(vecs[i].rec);
            check("lat1_valid", out_valid_o, 1'b0);
            check("lat1_level", fifo_level_o, 5'd1);
            step();
            check("lat2_valid", out_valid_o, 1'b1);
            check("lat2_level", fifo_level_o, 5'd0);
            check_hdr(s);
            check_words(vecs[i], 0);
            check("single_idle", out_valid_o, 1'b0);
        end

        // Backpressure mid-record: 5 stalled cycles on word 1
        s = seq_exp;
        push(vecs[1].rec);
        wait_valid("bp");
        check_hdr(s);
        check("bp_w0", out_data_o, 32'hAAAAAAAA);
        step();
        out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_hold_valid", out_valid_o, 1'b1);
            check("bp_hold_data", out_data_o, 32'hBBBBBBBB);
            check("bp_hold_last", out_last_o, 1'b0);
        end
        out_ready_i = 1'b1;
        check_words(vecs[1], 1);
        check("bp_idle", out_valid_o, 1'b0);

        // Back-to-back: three queued records stream without a bubble
        out_ready_i = 1'b0;
        s = seq_exp;
        push(vecs[1].rec);
        push(vecs[2].rec);
        push(vecs[3].rec);
        check("b2b_level", fifo_level_o, 5'd2);
        out_ready_i = 1'b1;
        for (int r = 1; r < 4; r++) begin
            check_hdr(s + 16'(r - 1));
            check_words(vecs[r], 0);
        end
        check("b2b_idle", out_valid_o, 1'b0);

        // Overflow: 20 pushes with the sink stalled -> 1 in shift reg, 16 queued, 3 dropped
        out_ready_i = 1'b0;
        s = seq_exp;
        for (int i = 0; i < 20; i++) push(128'(i));
        check("ovf_level", fifo_level_o, 5'd16);
        check("ovf_drop", drop_count_o, 16'd3);
        check("ovf_flag", overflow_o, 1'b1);
        check("ovf_valid", out_valid_o, 1'b1);

        // Clear coinciding with a drop: clear wins
        clr_overflow_i = 1'b1;
        push(128'hBAD);
        clr_overflow_i = 1'b0;
        check("clr_win_drop", drop_count_o, 16'd0);
        check("clr_win_flag", overflow_o, 1'b0);
        check("clr_win_level", fifo_level_o, 5'd16);

        push(128'hBAD);
        check("redrop_count", drop_count_o, 16'd1);
        check("redrop_flag", overflow_o, 1'b1);
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;
        check("clr_drop", drop_count_o, 16'd0);
        check("clr_flag", overflow_o, 1'b0);

        // Pop of last word and push on a full FIFO in the same cycle: push still dropped
        out_ready_i = 1'b1;
        n = 0;
        while (!out_last_o && n < 10) begin
            step();
            n++;
        end
        check("prepop_last_timeout", out_last_o, 1'b1);
        check("prepop_level_before", fifo_level_o, 5'd16);
        push(128'hBEEF);
        check("prepop_level", fifo_level_o, 5'd15);
        check("prepop_drop", drop_count_o, 16'd1);
        check("prepop_valid", out_valid_o, 1'b1);
`ifdef GOURAM_TRACE_HEADER_EN
        check("prepop_next_hdr", out_data_o, {8'hA5, 8'h04, s + 16'd1});
`else
        check("prepop_next_w0", out_data_o, 32'h1);
`endif

        // Async reset mid-record: outputs drop without a clock edge, queue discarded
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", out_valid_o, 1'b0);
        check("arst_last", out_last_o, 1'b0);
        check("arst_data", out_data_o, 32'h0);
        check("arst_level", fifo_level_o, 5'd0);
        check("arst_drop", drop_count_o, 16'd0);
        check("arst_flag", overflow_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        seq_exp = '0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid_o) n++;
        end
        check("arst_no_words", n, 0);

        // Normal operation resumes after reset
        s = seq_exp;
        push(vecs[0].rec);
        wait_valid("post_rst");
        check_hdr(s);
        check_words(vecs[0], 0);
        check("post_rst_idle", out_valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
